// File: rtl/zautoconfig_multi.sv
// zautoconfig_multi: Zorro II/III Autoconfig responder presenting NUM_BOARDS logical boards in turn
// Ports: CLK/RESET_n clock and async active-low reset; cfg_match, ADDRL, FCS_n, READ, DS_n, DIN, FC
// bus-side config access; CFGIN_n/CFGOUT_n autoconfig chain; DOUT registered read nibble;
// autoconfig_cycle config-space cycle flag; cur_board/configured/addr_match board state;
// mem_addr/ram_hit per-board memory select for the memory controllers.
module zautoconfig_multi #(
    parameter int          NUM_BOARDS   = 2,
    parameter bit          ZORRO3       = 1,
    parameter logic [15:0] MFG_ID       = 16'h07DB,
    parameter logic [7:0]  PROD_ID_BASE = 8'h72,
    parameter logic [31:0] SERIAL       = 32'd421,
    parameter logic [15:0] SIZE_CODES   = 16'h4444
) (
    input  logic                    CLK,
    input  logic                    RESET_n,
    input  logic                    cfg_match,
    input  logic [3:0]              mem_addr,
    input  logic [6:0]              ADDRL,
    input  logic                    FCS_n,
    input  logic                    READ,
    input  logic                    DS_n,
    input  logic                    CFGIN_n,
    input  logic [3:0]              DIN,
    input  logic [2:0]              FC,
    output logic [3:0]              DOUT,
    output logic                    autoconfig_cycle,
    output logic                    CFGOUT_n,
    output logic [1:0]              cur_board,
    output logic [NUM_BOARDS-1:0]   configured,
    output logic [4*NUM_BOARDS-1:0] addr_match,
    output logic [NUM_BOARDS-1:0]   ram_hit
);
    logic [1:0]              vs_q;
    logic [3:0]              dout_q;
    logic [1:0]              cur_q, cur_d;
    logic [NUM_BOARDS-1:0]   cfg_q, cfg_d, shut_q, shut_d;
    logic [4*NUM_BOARDS-1:0] base_q, base_d;
    logic                    armed_q, cfgout_q;
    logic                    all_done, acc, wr, wr_cfg, wr_shut, taken;
    logic [6:0]              idx;
    logic [7:0]              prod;
    logic [2:0]              sn;
    logic [3:0]              rom;
    logic                    unused_fc2;

    assign unused_fc2       = FC[2];
    assign idx              = {ADDRL[5:0], ADDRL[6]};
    assign all_done         = &(cfg_q | shut_q);
    assign autoconfig_cycle = cfg_match & ~CFGIN_n & cfgout_q & vs_q[1] & ~all_done;
    assign acc              = autoconfig_cycle & ~FCS_n & armed_q;
    assign wr_cfg           = acc & ~READ & ~DS_n & (idx == 7'h11);
    assign wr_shut          = acc & ~READ & ~DS_n & (idx == 7'h13);
    assign wr               = wr_cfg | wr_shut;
    assign prod             = PROD_ID_BASE + {6'd0, cur_q};
    // serial nibble select: index 0x0C reads bits [31:28], index 0x13 reads bits [3:0]
    assign sn               = 3'd3 - idx[2:0];

    assign DOUT       = dout_q;
    assign CFGOUT_n   = cfgout_q;
    assign cur_board  = cur_q;
    assign configured = cfg_q;
    assign addr_match = base_q;

    always_comb begin
        rom = 4'hF;
        if (idx == 7'h00) rom = ZORRO3 ? 4'b1010 : 4'b1110;
        else if (idx == 7'h01) rom = SIZE_CODES[{cur_q, 2'b00} +: 4];
        else if (idx == 7'h02) rom = ~prod[7:4];
        else if (idx == 7'h03) rom = ~prod[3:0];
        else if (idx == 7'h04) rom = ZORRO3 ? ~4'b1011 : ~4'b1000;
        else if (idx == 7'h05) rom = ~4'b0001;
        else if (idx >= 7'h08 && idx <= 7'h0B) rom = ~MFG_ID[{~idx[1:0], 2'b00} +: 4];
        else if (idx >= 7'h0C && idx <= 7'h13) rom = ~SERIAL[{sn, 2'b00} +: 4];
        else if (idx == 7'h20 || idx == 7'h21) rom = 4'h0;
    end

    // a config/shut-up write retires the current board and moves to the next pending one
    always_comb begin
        cfg_d  = cfg_q;
        shut_d = shut_q;
        base_d = base_q;
        cur_d  = cur_q;
        for (int i = 0; i < NUM_BOARDS; i++)
            if (cur_q == 2'(i)) begin
                if (wr_cfg) begin
                    cfg_d[i]         = 1'b1;
                    base_d[4*i +: 4] = DIN;
                end
                if (wr_shut) shut_d[i] = 1'b1;
            end
        if (wr) begin
            cur_d = 2'(NUM_BOARDS - 1);
            for (int i = NUM_BOARDS - 1; i >= 0; i--)
                if (2'(i) > cur_q && !cfg_d[i] && !shut_d[i]) cur_d = 2'(i);
        end
    end

    // equal bases resolve to the lowest board so the selects stay one-hot
    always_comb begin
        ram_hit = '0;
        taken   = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++)
            if (!cfg_match && vs_q[1] && cfg_q[i] && !shut_q[i] &&
                mem_addr == base_q[4*i +: 4] && !taken) begin
                ram_hit[i] = 1'b1;
                taken      = 1'b1;
            end
    end

    // armed drops after a write so a long bus cycle cannot also configure the next board
    always_ff @(posedge CLK or negedge RESET_n)
        if (!RESET_n) begin
            vs_q    <= '0;
            dout_q  <= '0;
            cur_q   <= '0;
            cfg_q   <= '0;
            shut_q  <= '0;
            base_q  <= '1;
            armed_q <= 1'b1;
        end else begin
            vs_q    <= {vs_q[0], FC[1] ^ FC[0]};
            if (acc & READ) dout_q <= rom;
            cur_q   <= cur_d;
            cfg_q   <= cfg_d;
            shut_q  <= shut_d;
            base_q  <= base_d;
            armed_q <= FCS_n | (armed_q & ~wr);
        end

    // the chain is only passed on once the bus cycle that finished the last board ends
    always_ff @(posedge FCS_n or negedge RESET_n)
        if (!RESET_n) cfgout_q <= 1'b1;
        else cfgout_q <= ~all_done;
endmodule

// File: doc/zautoconfig_multi.md
Name: zautoconfig_multi

Overview:
- Parametrised Zorro II/III Autoconfig responder presenting up to 4 logical boards in sequence from one CPLD.
- Each board has its own size code, product ID, base-address nibble, configured flag and shut-up flag.
- The block drives CFGOUT_n only after every board is configured or shut up.
- It sits between the bus decode (cfg_match, FCS_n, FC) and the memory controllers, which consume ram_hit.

Parameters:
- NUM_BOARDS, 2, number of logical boards (1..4)
- ZORRO3, 1, 1 = Zorro III type/flag nibbles, 0 = Zorro II
- MFG_ID, 16'h07DB, manufacturer ID shared by all boards
- PROD_ID_BASE, 8'h72, product ID of board 0; board i reports PROD_ID_BASE+i (8-bit wrap)
- SERIAL, 32'd421, serial number shared by all boards
- SIZE_CODES, 16'h4444, packed 4-bit size nibble per board; board i uses bits [4i+3:4i]

Ports:
- CLK  in  1  system clock
- RESET_n  in  1  async active-low reset
- cfg_match  in  1  address is in the autoconfig space
- mem_addr  in  4  address nibble compared against each board's base
- ADDRL  in  7  low address bits; register index = {ADDRL[5:0],ADDRL[6]}
- FCS_n  in  1  bus cycle strobe, active low
- READ  in  1  1 = read cycle
- DS_n  in  1  data strobe, active low
- CFGIN_n  in  1  chain input, active low
- DIN  in  4  write data nibble
- FC  in  3  function code
- DOUT  out  4  read data nibble
- autoconfig_cycle  out  1  the current cycle targets this block's config space
- CFGOUT_n  out  1  chain output, active low
- cur_board  out  2  index of the board currently presented
- configured  out  NUM_BOARDS  per-board configured flag
- addr_match  out  4*NUM_BOARDS  per-board base nibble
- ram_hit  out  NUM_BOARDS  per-board memory select

Behaviour:
- Reset (async) values:
  - DOUT=0, CFGOUT_n=1, cur_board=0, configured=0, shut-up flags=0.
  - addr_match all nibbles 4'hF.
  - vs=0, armed=1.
- Valid space:
  - validspace = FC[1]^FC[0].
  - Synchronised through a 2-flop shift register vs; vs[1] is used everywhere.
- autoconfig_cycle = cfg_match & !CFGIN_n & CFGOUT_n & vs[1] & !all_done.
  - all_done: every board is configured or shut up.
- Access qualification: an access is accepted only when autoconfig_cycle & !FCS_n & armed at the CLK edge.
- armed:
  - Clears on the first CLK edge on which a write takes effect.
  - Sets again on the first CLK edge with FCS_n=1.
  - Guarantees one bus cycle configures at most one board, even though cur_board advances mid-cycle.
- Reads:
  - DOUT is registered; 1-cycle latency from the qualifying edge.
  - ROM index:
    - 0x00: ZORRO3 ? 4'b1010 : 4'b1110
    - 0x01: SIZE_CODES nibble of cur_board
    - 0x02/0x03: ~product ID hi/lo
    - 0x04: ZORRO3 ? ~4'b1011 : ~4'b1000
    - 0x05: ~4'b0001
    - 0x08..0x0B: ~MFG_ID nibbles, MSB first
    - 0x0C..0x13: ~SERIAL nibbles, MSB first
    - 0x20/0x21: 0
    - all others: F
  - Reads do not clear armed.
- Writes (require !DS_n):
  - Index 0x11: addr_match[cur_board] <= DIN; configured[cur_board] <= 1.
  - Index 0x13: shut-up[cur_board] <= 1.
  - Either write advances cur_board to the next board that is neither configured nor shut up, and clears armed.
  - Other indices are ignored.
- Board sequencing:
  - cur_board runs 0..NUM_BOARDS-1 and never wraps.
  - After the last board, all_done=1 and cur_board holds at NUM_BOARDS-1.
- CFGOUT_n:
  - Registered on the rising edge of FCS_n (async reset to 1).
  - CFGOUT_n <= !all_done.
  - Goes low at the end of the bus cycle that completed the last board.
- ram_hit[i] = !cfg_match & vs[1] & configured[i] & !shutup[i] & (mem_addr == addr_match[i]).
  - If two bases are equal, the lowest index wins; others are forced 0 (one-hot or zero).
- Reset mid-cycle: all state returns to reset values immediately; a pending write is lost.
- CFGIN_n high: no response; reads leave DOUT unchanged.

Test Plan:
- Reset, then read index 0x00 and 0x01 for board 0 with ZORRO3=1 and SIZE_CODES=16'h4324 -> DOUT=4'hA, then 4'h4. After configuring board 0, index 0x01 reads 4'h2.
- Read index 0x03 on board 1 with PROD_ID_BASE=8'h72 -> DOUT=~4'h3=4'hC. Read index 0x13 -> ~(421&4'hF)=4'hA.
- Write DIN=4'h4 to 0x11 and hold FCS_n low for 5 CLKs -> only board 0 configured, addr_match[3:0]=4, cur_board=1. Board 1 stays unconfigured until a new cycle.
- Configure board 0 (base 4) and shut up board 1 -> CFGOUT_n stays 1 until FCS_n rises, then 0. Further cfg cycles give autoconfig_cycle=0.
- Give both boards base 4'h4 with mem_addr=4, cfg_match=0 -> ram_hit=2'b01. A shut-up board never hits.
- Assert RESET_n low mid-write with FCS_n low -> configured=0, addr_match=F, CFGOUT_n=1 immediately.
